// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-capped arbiter that gives two requesters
// exclusive turns at the async FIFO write port.
module fifo_wr_arbiter #(
  parameter int D_SIZE    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  input  logic [D_SIZE-1:0] i_req0_data,
  input  logic              i_req0_last,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [D_SIZE-1:0] i_req1_data,
  input  logic              i_req1_last,
  output logic              o_req1_ready,
  input  logic              i_fifo_full,
  output logic              o_fifo_inc,
  output logic [D_SIZE-1:0] o_fifo_wdata,
  output logic [1:0]        o_grant,
  output logic              o_busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          xfer;
  logic          last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    cnt_d        = cnt_q;
    xfer         = 1'b0;
    last         = 1'b0;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_fifo_wdata = '0;
    o_grant      = 2'b00;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_req0_valid && (!i_req1_valid || !prio_q))
          state_d = OWN0;
        else if (i_req1_valid)
          state_d = OWN1;
      end
      OWN0: begin
        o_grant      = 2'b01;
        o_req0_ready = !i_fifo_full;
        xfer         = i_req0_valid && !i_fifo_full;
        last         = i_req0_last;
        o_fifo_wdata = i_req0_data;
      end
      OWN1: begin
        o_grant      = 2'b10;
        o_req1_ready = !i_fifo_full;
        xfer         = i_req1_valid && !i_fifo_full;
        last         = i_req1_last;
        o_fifo_wdata = i_req1_data;
      end
      default: state_d = IDLE;
    endcase
    // Packet end or burst cap hands priority to the other side.
    if (xfer) begin
      if (last || cnt_q == CNT_LAST) begin
        state_d = IDLE;
        prio_d  = (state_q == OWN0);
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign o_fifo_inc = xfer;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: contention, burst cap,
// backpressure, valid gaps and asynchronous reset.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, l0 = 1'b0;
  logic        v1 = 1'b0, l1 = 1'b0;
  logic [15:0] d0 = '0, d1 = '0;
  logic        full = 1'b0;
  logic        r0, r1, inc, busy;
  logic [15:0] wd;
  logic [1:0]  gnt;

  int n_chk = 0;
  int n_fail = 0;

  fifo_wr_arbiter #(
    .D_SIZE   (16),
    .MAX_BURST(8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req0_valid(v0),
    .i_req0_data (d0),
    .i_req0_last (l0),
    .o_req0_ready(r0),
    .i_req1_valid(v1),
    .i_req1_data (d1),
    .i_req1_last (l1),
    .o_req1_ready(r1),
    .i_fifo_full (full),
    .o_fifo_inc  (inc),
    .o_fifo_wdata(wd),
    .o_grant     (gnt),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [1:0] eg,
                       input logic er0, input logic er1,
                       input logic einc,
                       input logic [15:0] ewd);
    logic [21:0] obs, exp;
    obs = {gnt, busy, r0, r1, inc, wd};
    exp = {eg, |eg, er0, er1, einc, ewd};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, then check outputs mid-cycle.
  task automatic cyc(input string tag,
                     input logic a_v0, input logic [15:0] a_d0,
                     input logic a_l0,
                     input logic a_v1, input logic [15:0] a_d1,
                     input logic a_l1, input logic a_full,
                     input logic [1:0] eg,
                     input logic er0, input logic er1,
                     input logic einc, input logic [15:0] ewd);
    @(posedge clk);
    #1;
    v0 = a_v0; d0 = a_d0; l0 = a_l0;
    v1 = a_v1; d1 = a_d1; l1 = a_l1;
    full = a_full;
    #1;
    check(tag, eg, er0, er1, einc, ewd);
  endtask

  initial begin
    #2;
    check("reset", 2'b00, 0, 0, 0, 16'h0);
    #10;
    rst = 1'b0;

    // contention from reset, prio 0
    cyc("c1", 1, 16'ha000, 0, 1, 16'hb000, 0, 0, 2'b00, 0, 0, 0, 16'h0);
    cyc("c2", 1, 16'ha000, 0, 1, 16'hb000, 0, 0, 2'b01, 1, 0, 1, 16'ha000);
    cyc("c3", 1, 16'ha001, 0, 1, 16'hb000, 0, 0, 2'b01, 1, 0, 1, 16'ha001);
    cyc("c4", 1, 16'ha002, 1, 1, 16'hb000, 0, 0, 2'b01, 1, 0, 1, 16'ha002);
    cyc("c5", 0, 16'h0, 0, 1, 16'hb000, 0, 0, 2'b00, 0, 0, 0, 16'h0);
    cyc("c6", 0, 16'h0, 0, 1, 16'hb000, 0, 0, 2'b10, 0, 1, 1, 16'hb000);
    cyc("c7", 0, 16'h0, 0, 1, 16'hb001, 0, 0, 2'b10, 0, 1, 1, 16'hb001);
    cyc("c8", 0, 16'h0, 0, 1, 16'hb002, 1, 0, 2'b10, 0, 1, 1, 16'hb002);
    cyc("c9", 1, 16'hc000, 1, 1, 16'hd000, 0, 0, 2'b00, 0, 0, 0, 16'h0);
    cyc("c10", 1, 16'hc000, 1, 1, 16'hd000, 0, 0, 2'b01, 1, 0, 1, 16'hc000);
    cyc("c11", 1, 16'he000, 1, 1, 16'hd000, 1, 0, 2'b00, 0, 0, 0, 16'h0);
    cyc("c12", 1, 16'he000, 1, 1, 16'hd000, 1, 0, 2'b10, 0, 1, 1, 16'hd000);
    cyc("c13", 1, 16'he000, 1, 0, 16'h0, 0, 0, 2'b00, 0, 0, 0, 16'h0);
    cyc("c14", 1, 16'he000, 1, 0, 16'h0, 0, 0, 2'b01, 1, 0, 1, 16'he000);
    cyc("c15", 0, 16'h0, 0, 0, 16'h0, 0, 0, 2'b00, 0, 0, 0, 16'h0);

    // single requester, 4-word packet
    cyc("s1", 1, 16'h5000, 0, 0, 16'h0, 0, 0, 2'b00, 0, 0, 0, 16'h0);
    cyc("s2", 1, 16'h5000, 0, 0, 16'h0, 0, 0, 2'b01, 1, 0, 1, 16'h5000);
    cyc("s3", 1, 16'h5001, 0, 0, 16'h0, 0, 0, 2'b01, 1, 0, 1, 16'h5001);
    cyc("s4", 1, 16'h5002, 0, 0, 16'h0, 0, 0, 2'b01, 1, 0, 1, 16'h5002);
    cyc("s5", 1, 16'h5003, 1, 0, 16'h0, 0, 0, 2'b01, 1, 0, 1, 16'h5003);
    cyc("s6", 0, 16'h0, 0, 0, 16'h0, 0, 0, 2'b00, 0, 0, 0, 16'h0);

    // burst cap: req1 streams 20 words, prio is 1 here
    cyc("b0", 1, 16'h7000, 1, 1, 16'h1000, 0, 0, 2'b00, 0, 0, 0, 16'h0);
    for (int i = 0; i < 8; i++)
      cyc($sformatf("burst_a%0d", i),
          1, 16'h7000, 1, 1, 16'h1000 + 16'(i), 0, 0,
          2'b10, 0, 1, 1, 16'h1000 + 16'(i));
    cyc("b1", 1, 16'h7000, 1, 1, 16'h1008, 0, 0, 2'b00, 0, 0, 0, 16'h0);
    cyc("b2", 1, 16'h7000, 1, 1, 16'h1008, 0, 0, 2'b01, 1, 0, 1, 16'h7000);
    cyc("b3", 0, 16'h0, 0, 1, 16'h1008, 0, 0, 2'b00, 0, 0, 0, 16'h0);
    for (int i = 8; i < 16; i++)
      cyc($sformatf("burst_b%0d", i),
          0, 16'h0, 0, 1, 16'h1000 + 16'(i), 0, 0,
          2'b10, 0, 1, 1, 16'h1000 + 16'(i));
    cyc("b4", 0, 16'h0, 0, 1, 16'h1010, 0, 0, 2'b00, 0, 0, 0, 16'h0);
    for (int i = 16; i < 20; i++)
      cyc($sformatf("burst_c%0d", i),
          0, 16'h0, 0, 1, 16'h1000 + 16'(i), 0, 0,
          2'b10, 0, 1, 1, 16'h1000 + 16'(i));

    // valid gap: owner req1 idles while req0 waits
    for (int i = 0; i < 3; i++)
      cyc($sformatf("gap%0d", i),
          1, 16'h9000, 1, 0, 16'h1014, 0, 0,
          2'b10, 0, 1, 0, 16'h1014);
    cyc("g4", 1, 16'h9000, 1, 1, 16'h1014, 1, 0, 2'b10, 0, 1, 1, 16'h1014);
    cyc("g5", 1, 16'h9000, 1, 0, 16'h0, 0, 0, 2'b00, 0, 0, 0, 16'h0);
    cyc("g6", 1, 16'h9000, 1, 0, 16'h0, 0, 0, 2'b01, 1, 0, 1, 16'h9000);

    // full backpressure after word 2 of a 4-word packet
    cyc("f1", 1, 16'h6000, 0, 0, 16'h0, 0, 0, 2'b00, 0, 0, 0, 16'h0);
    cyc("f2", 1, 16'h6000, 0, 0, 16'h0, 0, 0, 2'b01, 1, 0, 1, 16'h6000);
    cyc("f3", 1, 16'h6001, 0, 0, 16'h0, 0, 0, 2'b01, 1, 0, 1, 16'h6001);
    for (int i = 0; i < 5; i++)
      cyc($sformatf("full%0d", i),
          1, 16'h6002, 0, 0, 16'h0, 0, 1,
          2'b01, 0, 0, 0, 16'h6002);
    cyc("f4", 1, 16'h6002, 0, 0, 16'h0, 0, 0, 2'b01, 1, 0, 1, 16'h6002);
    cyc("f5", 1, 16'h6003, 1, 0, 16'h0, 0, 0, 2'b01, 1, 0, 1, 16'h6003);
    cyc("f6", 0, 16'h0, 0, 0, 16'h0, 0, 0, 2'b00, 0, 0, 0, 16'h0);

    // reset mid-OWN1 after 3 words
    cyc("r1", 0, 16'h0, 0, 1, 16'h3000, 0, 0, 2'b00, 0, 0, 0, 16'h0);
    cyc("r2", 0, 16'h0, 0, 1, 16'h3000, 0, 0, 2'b10, 0, 1, 1, 16'h3000);
    cyc("r3", 0, 16'h0, 0, 1, 16'h3001, 0, 0, 2'b10, 0, 1, 1, 16'h3001);
    cyc("r4", 0, 16'h0, 0, 1, 16'h3002, 0, 0, 2'b10, 0, 1, 1, 16'h3002);
    @(posedge clk);
    #1;
    d1 = 16'h3003;
    v0 = 1'b1; d0 = 16'h4000; l0 = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("rst_async", 2'b00, 0, 0, 0, 16'h0);
    #3;
    rst = 1'b0;
    #1;
    check("rst_idle", 2'b00, 0, 0, 0, 16'h0);
    cyc("r5", 1, 16'h4000, 1, 1, 16'h3003, 0, 0, 2'b01, 1, 0, 1, 16'h4000);
    cyc("r6", 0, 16'h0, 0, 1, 16'h3003, 1, 0, 2'b00, 0, 0, 0, 16'h0);
    cyc("r7", 0, 16'h0, 0, 1, 16'h3003, 1, 0, 2'b10, 0, 1, 1, 16'h3003);
    cyc("r8", 0, 16'h0, 0, 0, 16'h0, 0, 0, 2'b00, 0, 0, 0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Two-requester, burst-aware write-port arbiter for the async FIFO, in the FIFO write clock domain. It grants one requester at a time exclusive access to the FIFO write port (`i_w_inc` / `i_w_data` / `o_full` of the FIFO). A grant lasts until that requester marks the end of its packet or a maximum burst length is reached. Requesters alternate round-robin, so packets never interleave in the FIFO and neither source starves the other.

## Interface
- `D_SIZE`, 16: data width; matches the FIFO `D_SIZE`.
- `MAX_BURST`, 8: maximum words per grant, range 1..255. Counter width is `$clog2(MAX_BURST+1)`.

Ports (name, direction, width, meaning):
- `i_clk` in 1: FIFO write-domain clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_req0_valid` in 1: requester 0 has a word.
- `i_req0_data` in `D_SIZE`: requester 0 word.
- `i_req0_last` in 1: requester 0 word is the last of its packet.
- `o_req0_ready` out 1: requester 0 word accepted this cycle when valid && ready.
- `i_req1_valid`, `i_req1_data`, `i_req1_last`, `o_req1_ready`: same meanings, for requester 1.
- `i_fifo_full` in 1: FIFO full flag (registered in write domain).
- `o_fifo_inc` out 1: FIFO write strobe.
- `o_fifo_wdata` out `D_SIZE`: FIFO write data.
- `o_grant` out 2: one-hot owner, bit0 = requester 0; 00 when idle.
- `o_busy` out 1: a grant is active.

## Operation
- States: IDLE, OWN0, OWN1. The state, the 1-bit priority pointer `prio` and the burst counter `cnt` are registered.
- In IDLE:
  - If no valid, stay in IDLE.
  - If exactly one valid, go to that requester's OWNx.
  - If both are valid, go to OWN0 when `prio==0`, otherwise OWN1.
  - `cnt` clears to 0.
- In OWNx:
  - `o_reqx_ready = !i_fifo_full`. The other requester's ready is 0.
  - Transfer `xfer = i_reqx_valid && o_reqx_ready`.
  - `o_fifo_inc = xfer`. `o_fifo_wdata = i_reqx_data` while in OWNx, 0 otherwise.
  - Each transfer increments `cnt`.
- Release: on a transfer with `i_reqx_last==1`, or a transfer with `cnt==MAX_BURST-1`:
  - next state is IDLE;
  - `prio` is set to the other requester;
  - `cnt` clears.
- Owner deasserts valid mid-packet: ownership is held and no writes occur. No timeout.
- FIFO full: ready is 0 and no write happens. The state and `cnt` hold until not full.
- `o_grant` and `o_busy` decode the state. They are 00/0 in IDLE.
- Requester rule: once valid is asserted, data and last must be held stable until accepted.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `prio` 0, `cnt` 0. All outputs are 0: `o_grant` 00, `o_busy` 0, both readies 0, `o_fifo_inc` 0, `o_fifo_wdata` 0.
- Grant latency: valid sampled in IDLE at edge N gives OWNx during cycle N+1. The first transfer can occur in cycle N+1.
- Throughput: one word per cycle while owned, valid and not full.
- Combinational paths: `i_fifo_full` and `i_reqx_valid` to `o_fifo_inc` and `o_reqx_ready`; `i_reqx_data` to `o_fifo_wdata`. There is no registered stage in the data path.
- Every grant is followed by at least one IDLE cycle. Back-to-back packets from alternating requesters therefore cost one bubble each.
- Reset asserted mid-burst: all state and outputs clear asynchronously. A partial packet may be left in the FIFO; the upstream reset policy handles this.
- `MAX_BURST==1`: every transfer releases the grant.

## Test plan
- Reset: assert `i_rst` mid-OWN1 with 3 words sent. Required response: all outputs 0 immediately, and after deassert the arbiter returns to IDLE with `prio` 0.
- Single requester: req0 sends 4 words, last on word 4, FIFO never full. Required response: grant in cycle 1, `o_fifo_inc` high for 4 consecutive cycles with data in order, then IDLE.
- Contention: both valid from reset with 3-word packets. Required response: req0 granted first, then one idle cycle, then req1; the next contention grants req0 again.
- Burst cap: `MAX_BURST=8`, req1 streams 20 words with no last while req0 waits. Required response: 8 words from req1, IDLE, 1 req0 packet, then req1 resumes.
- Full backpressure: raise `i_fifo_full` for 5 cycles after word 2 of a 4-word packet. Required response: ready and inc are 0 for those 5 cycles, `cnt` holds, and words 3–4 follow with no loss or duplication.
- Valid gap: owner drops valid for 3 cycles mid-packet while the other requester is valid. Required response: the grant is held and no foreign word is written.
